// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_pkg
// Description : Shared definitions for the instruction fetch stage: field bit
//               positions of a MIPS instruction word, the default reset PC,
//               the fetch state encoding and the FIFO entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

   // Default PC loaded on reset (start of MIPS user text segment)
   localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;

   // Instruction field bit positions
   localparam int OPCODE_HI = 31;
   localparam int OPCODE_LO = 26;
   localparam int RS_HI     = 25;
   localparam int RS_LO     = 21;
   localparam int RT_HI     = 20;
   localparam int RT_LO     = 16;
   localparam int RD_HI     = 15;
   localparam int RD_LO     = 11;
   localparam int FUNCT_HI  = 5;
   localparam int FUNCT_LO  = 0;
   localparam int IMM_HI    = 15;
   localparam int IMM_LO    = 0;

   // One FIFO entry carries the fetched word together with its PC
   localparam int ENTRY_W = 64;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fq_entry_t;

   // Fetch state encoding
   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fq_state_e;

endpackage : fetch_queue_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH x WIDTH circular buffer holding fetched {pc, instr}
//               entries. Head data is read combinationally. Flush empties the
//               buffer and overrides push/pop in the same cycle.
// Ports       : clock, reset (async, active-high)
//               flush      - empty the buffer
//               push       - write push_data at the tail
//               push_data  - entry to write
//               pop        - remove the head entry
//               head_data  - entry at the head (stale when count == 0)
//               count      - number of valid entries (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = ENTRY_W
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [AW-1:0] c_ptr_one = AW'(1);
   localparam logic [CW-1:0] c_cnt_one = CW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;

   // DEPTH is a power of two, so the pointers wrap modulo DEPTH on overflow.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (push) begin
            r_wptr <= r_wptr + c_ptr_one;
         end
         if (pop) begin
            r_rptr <= r_rptr + c_ptr_one;
         end
         case ({push, pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only observed after it was written.
   always_ff @(posedge clock) begin
      if (push && !flush) begin
         r_mem[r_wptr] <= push_data;
      end
   end

   assign head_data = r_mem[r_rptr];
   assign count     = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch stage feeding mips_decode. Holds the PC,
//               issues sequential reads to a synchronous instruction memory,
//               buffers returned words in fetch_fifo and presents the head
//               entry split into instruction fields over valid/ready.
//               Supports PC redirect and halts permanently on a decode
//               exception until reset.
// Ports       : clock, reset          - clock, async active-high reset
//               imem_req/imem_addr    - read request and word address
//               imem_rdata            - data for previous cycle's request
//               redirect_valid/_pc    - load new PC and flush the queue
//               inst_valid/inst_ready - head handshake with decode
//               opcode..imm16,inst_pc - fields and PC of the head entry
//               except                - decode exception for the head
//               halted                - fetch stopped after an exception
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [5:0]  funct,
   output logic [15:0] imm16,
   output logic [31:0] inst_pc,
   input  logic        except,
   output logic        halted
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] c_depth = (CW+1)'(DEPTH);

   fq_state_e     r_state;
   fq_state_e     w_state_nxt;
   logic [31:0]   r_pc;
   logic          r_pending;    // a read was issued last cycle
   logic          r_drop;       // that read's response must be discarded

   logic [CW-1:0] w_count;
   fq_entry_t     w_head;
   fq_entry_t     w_push_entry;
   logic [CW:0]   w_occ;
   logic          w_run;
   logic          w_redirect;
   logic          w_valid;
   logic          w_accept;
   logic          w_except_acc;
   logic          w_flush;
   logic          w_push;
   logic          w_pop;
   logic          w_issue;
   logic [31:0]   w_instr;
   logic [31:0]   w_ipc;

   assign w_run      = (r_state == ST_RUN);
   assign w_redirect = w_run && redirect_valid;
   assign w_valid    = w_run && (w_count != '0);
   assign w_accept   = w_valid && inst_ready;

   // Redirect outranks an exception raised in the same cycle.
   assign w_except_acc = w_accept && except && !redirect_valid;
   assign w_flush      = w_redirect || w_except_acc;
   assign w_pop        = w_accept && !w_flush;
   assign w_push       = w_run && r_pending && !r_drop && !w_flush;

   // Slots already reserved: buffered entries plus the read in flight. A pop
   // in this cycle deliberately does not free a slot, so a push can never
   // find the FIFO full.
   assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_pending};
   assign w_issue = !reset && w_run && !redirect_valid && (w_occ < c_depth);

   assign w_push_entry.pc    = r_pc - 32'd4;
   assign w_push_entry.instr = imem_rdata;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (w_flush),
      .push      (w_push),
      .push_data (w_push_entry),
      .pop       (w_pop),
      .head_data (w_head),
      .count     (w_count)
   );

   // ------------------------------------------------------------------
   // PC and in-flight request tracking
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pc      <= RESET_PC;
         r_pending <= 1'b0;
         r_drop    <= 1'b0;
      end else if (w_run) begin
         if (w_redirect) begin
            // Masking keeps the target word-aligned; no request this cycle.
            r_pc      <= redirect_pc & 32'hFFFF_FFFC;
            r_pending <= 1'b0;
            r_drop    <= r_pending;
         end else if (w_except_acc) begin
            r_pending <= 1'b0;
            r_drop    <= r_pending | w_issue;
         end else begin
            if (w_issue) begin
               r_pc <= r_pc + 32'd4;
            end
            r_pending <= w_issue;
            r_drop    <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_except_acc) begin
               w_state_nxt = ST_HALT;
            end
         end
         ST_HALT: begin
            w_state_nxt = ST_HALT;
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs. Fields read zero while no entry is presented.
   // ------------------------------------------------------------------
   assign w_instr = w_valid ? w_head.instr : 32'd0;
   assign w_ipc   = w_valid ? w_head.pc    : 32'd0;

   assign imem_req   = w_issue;
   assign imem_addr  = r_pc;
   assign inst_valid = w_valid;
   assign halted     = (r_state == ST_HALT);

   assign opcode  = w_instr[OPCODE_HI:OPCODE_LO];
   assign rs      = w_instr[RS_HI:RS_LO];
   assign rt      = w_instr[RT_HI:RT_LO];
   assign rd      = w_instr[RD_HI:RD_LO];
   assign funct   = w_instr[FUNCT_HI:FUNCT_LO];
   assign imm16   = w_instr[IMM_HI:IMM_LO];
   assign inst_pc = w_ipc;

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue. Instruction memory
//               returns the request address as data. An expected-PC stream
//               is loaded whenever fetch is (re)started and every accepted
//               instruction is popped from it and compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'd0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  funct;
   logic [15:0] imm16;
   logic [31:0] inst_pc;
   logic        except = 1'b0;
   logic        halted;

   int          total = 0;
   int          bad = 0;
   int          req_cnt = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;

   fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RPC)
   ) dut (
      .clock          (clk),
      .reset          (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .opcode         (opcode),
      .rs             (rs),
      .rt             (rt),
      .rd             (rd),
      .funct          (funct),
      .imm16          (imm16),
      .inst_pc        (inst_pc),
      .except         (except),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory: data = address of last cycle's read
   always @(posedge clk) imem_rdata <= imem_addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic load_stream(input logic [31:0] start, input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: request counting, overflow guard and scoreboard compare
   always @(negedge clk) begin
      if (imem_req) req_cnt++;
      check1("push_into_full",
             dut.u_fifo.push && (32'(dut.u_fifo.count) == DEPTH), 1'b0);
      if (inst_valid && inst_ready && !redirect_valid) begin
         check1("stream_empty", exp_q.size() == 0, 1'b0);
         if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check("inst_pc", inst_pc, mon_exp);
            check("inst_word", {opcode, rs, rt, imm16}, mon_exp);
            check("rd_funct", {21'd0, rd, funct}, {21'd0, mon_exp[15:11], mon_exp[5:0]});
         end
      end
   end

   initial begin
      // ---------------- reset values ----------------
      repeat (2) @(posedge clk);
      #1;
      check1("rst_req", imem_req, 1'b0);
      check1("rst_valid", inst_valid, 1'b0);
      check1("rst_halted", halted, 1'b0);
      check("rst_fields", {opcode, rs, rt, imm16}, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);

      // ---------------- start-up timing ----------------
      load_stream(RPC, 64);
      inst_ready = 1'b1;
      rst = 1'b0;
      #1;
      check1("c0_req", imem_req, 1'b1);
      check("c0_addr", imem_addr, RPC);
      step();
      check("c1_addr", imem_addr, RPC + 32'd4);
      check1("c1_valid", inst_valid, 1'b0);
      step();
      check1("c2_valid", inst_valid, 1'b1);
      check("c2_inst_pc", inst_pc, RPC);
      check("c2_word", {opcode, rs, rt, imm16}, RPC);
      for (int i = 0; i < 6; i++) begin
         step();
         check1("steady_valid", inst_valid, 1'b1);
      end

      // ---------------- redirect with response in flight ----------------
      check1("pre_redir_pending", dut.r_pending, 1'b1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0040_0103;
      load_stream(32'h0040_0100, 64);
      #1;
      check1("redir_no_req", imem_req, 1'b0);
      step();
      redirect_valid = 1'b0;
      #1;
      check1("r1_req", imem_req, 1'b1);
      check("r1_addr", imem_addr, 32'h0040_0100);
      check1("r1_valid", inst_valid, 1'b0);
      step();
      check1("r2_valid", inst_valid, 1'b0);
      step();
      check1("r3_valid", inst_valid, 1'b1);
      check("r3_inst_pc", inst_pc, 32'h0040_0100);
      repeat (4) step();

      // ---------------- PC wrap-around ----------------
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      load_stream(32'hFFFF_FFF8, 16);
      step();
      redirect_valid = 1'b0;
      repeat (2) step();
      check("wrap_inst_pc", inst_pc, 32'hFFFF_FFF8);
      repeat (6) step();

      // ---------------- exception halts fetch ----------------
      redirect_valid = 1'b1;
      redirect_pc = 32'hDC00_0000;
      load_stream(32'hDC00_0000, 16);
      step();
      redirect_valid = 1'b0;
      repeat (2) step();
      check1("exc_head_valid", inst_valid, 1'b1);
      check("exc_opcode", {26'd0, opcode}, 32'h37);
      except = 1'b1;
      step();
      except = 1'b0;
      req_cnt = 0;
      #1;
      check1("halted", halted, 1'b1);
      check1("halt_valid", inst_valid, 1'b0);
      check1("halt_req", imem_req, 1'b0);
      repeat (5) step();
      redirect_valid = 1'b1;
      redirect_pc = RPC;
      step();
      redirect_valid = 1'b0;
      repeat (13) step();
      check("halt_req_count", 32'(req_cnt), 32'd0);
      check1("halt_sticky", halted, 1'b1);
      check1("halt_valid_late", inst_valid, 1'b0);

      // ---------------- backpressure from reset ----------------
      rst = 1'b1;
      #1;
      check1("rst2_halted", halted, 1'b0);
      inst_ready = 1'b0;
      load_stream(RPC, 64);
      step();
      rst = 1'b0;
      req_cnt = 0;
      repeat (10) step();
      check("bp_req_count", 32'(req_cnt), 32'd4);
      check1("bp_req_idle", imem_req, 1'b0);
      check1("bp_valid", inst_valid, 1'b1);
      check("bp_inst_pc", inst_pc, RPC);
      inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check1("bp_drain_valid", inst_valid, 1'b1);
      end
      check("half_full", 32'(dut.u_fifo.count), 32'd2);

      // ---------------- asynchronous reset mid-stream ----------------
      #2;
      rst = 1'b1;
      #1;
      check1("arst_req", imem_req, 1'b0);
      check1("arst_valid", inst_valid, 1'b0);
      check1("arst_halted", halted, 1'b0);
      check("arst_fields", {opcode, rs, rt, imm16}, 32'd0);
      check("arst_inst_pc", inst_pc, 32'd0);
      load_stream(RPC, 64);
      step();
      rst = 1'b0;
      #1;
      check1("rs_c0_req", imem_req, 1'b1);
      check("rs_c0_addr", imem_addr, RPC);
      step();
      check1("rs_c1_valid", inst_valid, 1'b0);
      step();
      check1("rs_c2_valid", inst_valid, 1'b1);
      check("rs_c2_inst_pc", inst_pc, RPC);
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fetch_queue
`default_nettype wire
